// File: rtl/shift_result_stage.sv
// Registered NZCV result stage behind the barrel shifter, with a two-entry skid buffer.
// Optional sticky overflow flag is built only when SHIFT_STICKY_V_EN is defined.
module shift_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] xfer_count,
  input  logic             clr_sticky,
  output logic             sticky_v
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } entry_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0] state, state_nxt;
  entry_t     head, skid, new_e;
  logic       in_xfer, out_xfer;
  logic       ld_head_new, ld_head_skid, ld_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // flags are fixed at capture and travel with the word
  always_comb begin
    new_e.result = in_result;
    new_e.flags  = {in_result[WIDTH-1], (in_result == '0), in_carry, in_overflow};
  end

  always_comb begin
    state_nxt    = state;
    ld_head_new  = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      S_EMPTY: if (in_xfer) begin
        ld_head_new = 1'b1;
        state_nxt   = S_ONE;
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_head_new = 1'b1;
        end else if (in_xfer) begin
          ld_skid   = 1'b1;
          state_nxt = S_TWO;
        end else if (out_xfer) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: if (out_xfer) begin
        ld_head_skid = 1'b1;
        state_nxt    = S_ONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // handshake outputs are registered copies of the next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != S_TWO);
      out_valid <= (state_nxt != S_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_head_new)       head <= new_e;
      else if (ld_head_skid) head <= skid;
      if (ld_skid)           skid <= new_e;
    end
  end

  assign out_result = head.result;
  assign out_flags  = head.flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       xfer_count <= '0;
    else if (in_xfer) xfer_count <= xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

`ifdef SHIFT_STICKY_V_EN
  // a new V=1 capture beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sticky_v <= 1'b0;
    else if (in_xfer && in_overflow) sticky_v <= 1'b1;
    else if (clr_sticky)             sticky_v <= 1'b0;
  end
`else
  logic clr_sticky_unused;
  assign clr_sticky_unused = clr_sticky;
  assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Scoreboarded bench for shift_result_stage: flag table, stream, backpressure, async reset, wrap, sticky V.
module tb_shift_result_stage;

  localparam int W  = 32;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic [3:0]   f;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } sb_t;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_carry, in_overflow;
  logic [W-1:0]  in_result, out_result;
  logic          out_valid, out_ready, clr_sticky, sticky_v;
  logic [3:0]    out_flags;
  logic [CW-1:0] xfer_count;

  shift_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .xfer_count(xfer_count),
    .clr_sticky(clr_sticky), .sticky_v(sticky_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  sb_t           sbq[$];
  int            occ = 0;
  logic [CW-1:0] cnt_m = '0;
  logic [3:0]    cur_flags = '0;
  bit            mon_en = 0;

  always @(negedge clk) begin
    bit in_x, out_x;
    if (mon_en) begin
      chk("in_ready", in_ready, occ != 2);
      chk("out_valid", out_valid, occ != 0);
      chk("xfer_count", xfer_count, cnt_m);
      in_x  = in_valid && (occ != 2);
      out_x = out_ready && (occ != 0);
      if (occ != 0) begin
        if (sbq.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          chk("out_result", out_result, sbq[0].r);
          chk("out_flags", out_flags, sbq[0].f);
        end
      end
      if (out_x && sbq.size() > 0) void'(sbq.pop_front());
      if (in_x) begin
        sbq.push_back('{r: in_result, f: cur_flags});
        cnt_m = cnt_m + 1'b1;
      end
      occ = occ + int'(in_x) - int'(out_x);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] r, input logic c, input logic v, input logic [3:0] f);
    in_valid    = 1'b1;
    in_result   = r;
    in_carry    = c;
    in_overflow = v;
    cur_flags   = f;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_result   = '0;
    in_carry    = 1'b0;
    in_overflow = 1'b0;
    cur_flags   = '0;
  endtask

  task automatic clear_model();
    sbq.delete();
    occ   = 0;
    cnt_m = '0;
  endtask

  vec_t tbl[6];
  logic exp_sticky;

  initial begin
    tbl[0] = '{r: 32'h0000_0000, c: 1'b1, v: 1'b0, f: 4'b0110};
    tbl[1] = '{r: 32'hFFFF_FFFF, c: 1'b0, v: 1'b0, f: 4'b1000};
    tbl[2] = '{r: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0, f: 4'b1000};
    tbl[3] = '{r: 32'h7FFF_FFFF, c: 1'b0, v: 1'b0, f: 4'b0000};
    tbl[4] = '{r: 32'h8000_0000, c: 1'b1, v: 1'b1, f: 4'b1011};
    tbl[5] = '{r: 32'h0000_0001, c: 1'b0, v: 1'b1, f: 4'b0001};
`ifdef SHIFT_STICKY_V_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif

    rst_n = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    idle();
    #13;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_xfer_count", xfer_count, 0);
    chk("rst_sticky_v", sticky_v, 0);
    #10 rst_n = 1'b1;
    cyc();
    chk("rst_in_ready", in_ready, 1);
    clear_model();
    mon_en = 1;

    // single word after reset
    drive(32'h0, 1'b1, 1'b0, 4'b0110);
    cyc();
    idle();
    chk("single_out_valid", out_valid, 1);
    chk("single_flags", out_flags, 4'b0110);
    chk("single_count", xfer_count, 1);
    cyc();

    // back-to-back table stream, one word per cycle
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].f);
      cyc();
      chk("stream_head", out_result, tbl[i].r);
      chk("stream_flags", out_flags, tbl[i].f);
    end
    idle();
    cyc(); cyc();
    chk("stream_drained", sbq.size(), 0);

    // backpressure: third word held until TWO drains
    out_ready = 1'b0;
    drive(32'h8000_0001, 1'b0, 1'b0, 4'b1000); cyc();
    drive(32'h0000_0000, 1'b0, 1'b0, 4'b0100); cyc();
    drive(32'h0000_1234, 1'b1, 1'b0, 4'b0010); cyc();
    cyc();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head_hold", out_result, 32'h8000_0001);
    out_ready = 1'b1;
    cyc(); cyc();
    idle();
    cyc(); cyc();
    chk("bp_drained", sbq.size(), 0);
    chk("bp_out_valid", out_valid, 0);

    // asynchronous reset while in TWO
    out_ready = 1'b0;
    drive(32'hAAAA_5555, 1'b0, 1'b1, 4'b1001); cyc();
    drive(32'h5555_AAAA, 1'b1, 1'b0, 4'b0010); cyc();
    idle();
    #1 mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_flags", out_flags, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_count", xfer_count, 0);
    chk("mid_rst_sticky", sticky_v, 0);
    cyc();
    #3 rst_n = 1'b1;
    clear_model();
    out_ready = 1'b1;
    cyc();
    mon_en = 1;
    cyc(); cyc();
    chk("post_rst_no_emit", out_valid, 0);

    // counter wrap at CNT_W=4
    for (int i = 0; i < 17; i++) begin
      drive(32'h100 + W'(i), 1'b0, 1'b0, 4'b0000);
      cyc();
    end
    idle();
    chk("wrap_count", xfer_count, 1);
    cyc(); cyc();

    // sticky overflow: set beats clear, holds, then clears
    clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
    chk("sticky_cleared", sticky_v, 0);
    drive(32'h0000_0005, 1'b0, 1'b1, 4'b0001);
    clr_sticky = 1'b1;
    cyc();
    idle();
    clr_sticky = 1'b0;
    chk("sticky_set_wins", sticky_v, exp_sticky);
    cyc();
    chk("sticky_hold", sticky_v, exp_sticky);
    clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
    chk("sticky_clear", sticky_v, 0);
    cyc(); cyc();
    chk("final_drained", sbq.size(), 0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
